bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Downstream consumer of the combinational binary-to-BCD converter.
- Captures its packed BCD output on a load strobe and drives a time-multiplexed common-anode/cathode seven-segment display, one digit per scan slot.
- Includes a prescaled scan counter, a digit pointer, a per-frame strobe and an overflow indication.
- Sits between the converter and the board's display pins.

Parameters:
- NUMBCDS, 4: number of BCD digits and display positions; the bcd input is 4*NUMBCDS bits wide.
- CLK_DIV, 50000: clock cycles per digit slot; must be ≥2.
- ACTIVE_LOW, 1: 1 inverts both seg and an at the output registers (active-low pins); 0 gives active-high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  capture bcd and ovf into the holding register at this clock edge.
- bcd  in  4*NUMBCDS  packed BCD; bits [3:0] are digit 0 (least significant).
- ovf  in  1  source value exceeded the NUMBCDS-digit range.
- seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}.
- an  out  NUMBCDS  digit enable, one-hot; an[i] enables digit i.
- frame_done  out  1  one-cycle pulse on the slot that shows digit NUMBCDS-1.

Behaviour:
- Reset, asynchronous, takes effect immediately and is held while reset=1:
  - bcd_q=0, ovf_q=0, prescaler=0, nxt=0, frame_done=0.
  - seg and an all inactive: seg=7'h00 and an=0 when ACTIVE_LOW=0; all ones when ACTIVE_LOW=1.
- Holding register: on a clock edge with load=1, bcd_q<=bcd and ovf_q<=ovf. There is no handshake; load may be held high continuously.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 in the cycle where prescaler==CLK_DIV-1.
  - The first tick after reset release occurs on the CLK_DIV-th rising edge.
- On a tick edge, all outputs are registered:
  - an <= one-hot of nxt.
  - seg <= pattern(digit nxt).
  - nxt <= (nxt==NUMBCDS-1) ? 0 : nxt+1.
  - frame_done <= (nxt==NUMBCDS-1).
- Between ticks: seg and an hold, and frame_done=0.
- Period: one digit slot = CLK_DIV cycles; one frame = NUMBCDS*CLK_DIV cycles.
- pattern(), before ACTIVE_LOW inversion:
  - Digits 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Nibble A..F: 40 (dash).
  - Blank: 00.
  - When ovf_q=1, every digit shows 40, overriding both digit value and blanking.
- Load and tick in the same cycle: the tick uses the old bcd_q/ovf_q. The new value is displayed from the next tick.
- Load mid-frame: the scan is not restarted; the remaining slots of the frame show the new value.
- Reset mid-scan: outputs go inactive asynchronously. After release, scanning restarts at digit 0 with a full CLK_DIV delay.
- an is always one-hot or all-inactive; two digits are never enabled at once.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN (leading-zero blanking).
- Defined: any digit i≥1 for which digits i..NUMBCDS-1 of bcd_q are all zero shows blank (00). Digit 0 is never blanked. The ovf_q dash override still applies. an still scans normally.
- Undefined: all digits show their value, including leading zeros.

Test Plan (CLK_DIV=4, NUMBCDS=4, ACTIVE_LOW=0 unless noted):
- Reset asserted mid-cycle, then released:
  - seg=00, an=0000 and frame_done=0 immediately.
  - The first change is on the 4th edge after release: an=0001.
  - The tick pattern repeats every 4 cycles.
- load with bcd=16'h0255:
  - Scan shows an=0001/seg=6D, an=0010/6D, an=0100/5B, an=1000/3F.
  - With BCD_SCAN_LZB_EN the an=1000 slot shows 00.
  - frame_done=1 only in the cycle after the an=1000 tick.
- load bcd=16'h9999, then in the same cycle as a tick load bcd=16'h0000:
  - The tick shows 6F.
  - The next slot shows 3F.
  - Frame length is 16 cycles.
- load ovf=1 with bcd=16'h6383: every slot shows 40 in both macro builds.
- load bcd=16'h0A00: the an=0100 slot shows 40; other slots show 3F (or 00 for leading digit 3 under LZB).
- ACTIVE_LOW=1, bcd=16'h0001: slot 0 gives seg=7'h79, an=4'b1110; reset gives seg=7'h7F, an=4'b1111.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Time-multiplexed seven-segment scanner fed from a packed BCD holding register.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_display_scan #(
  parameter int NUMBCDS    = 4,
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [4*NUMBCDS-1:0]   bcd,
  input  logic                   ovf,
  output logic [6:0]             seg,
  output logic [NUMBCDS-1:0]     an,
  output logic                   frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NW = (NUMBCDS > 1) ? $clog2(NUMBCDS) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [NW-1:0]      NXT_LAST   = NW'(NUMBCDS - 1);
  localparam logic [6:0]         SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUMBCDS-1:0] AN_OFF     = ACTIVE_LOW ? {NUMBCDS{1'b1}} : {NUMBCDS{1'b0}};

  // Active-high segment pattern; non-decimal nibbles render as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] dig);
    logic [6:0] pat;
    case (dig)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  logic [4*NUMBCDS-1:0] bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [NW-1:0]        nxt_q, nxt_d;
  logic [6:0]           seg_q, seg_d;
  logic [NUMBCDS-1:0]   an_q, an_d;
  logic                 frame_done_q, frame_done_d;

  logic                 tick_s;
  logic [3:0]           dig_s;
  logic                 blank_s;
  logic [6:0]           pat_s;
  logic [NUMBCDS-1:0]   an_on_s;

  // Next-state for holding register, prescaler and scan outputs.
  always_comb begin
    tick_s  = (presc_q == PRESC_LAST);
    dig_s   = 4'h0;
    an_on_s = {NUMBCDS{1'b0}};

    if (load) begin
      bcd_d = bcd;
      ovf_d = ovf;
    end else begin
      bcd_d = bcd_q;
      ovf_d = ovf_q;
    end

    presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);

    for (int i = 0; i < NUMBCDS; i++) begin
      dig_s      = (nxt_q == NW'(i)) ? bcd_q[4*i +: 4] : dig_s;
      an_on_s[i] = (nxt_q == NW'(i));
    end

`ifdef BCD_SCAN_LZB_EN
    // A digit is blank when it and every more significant digit are zero.
    blank_s = (nxt_q != {NW{1'b0}});
    for (int i = 0; i < NUMBCDS; i++) begin
      blank_s = ((NW'(i) >= nxt_q) && (bcd_q[4*i +: 4] != 4'h0)) ? 1'b0 : blank_s;
    end
`else
    blank_s = 1'b0;
`endif

    if (ovf_q) begin
      pat_s = 7'h40;
    end else if (blank_s) begin
      pat_s = 7'h00;
    end else begin
      pat_s = seg_decode(dig_s);
    end

    if (tick_s) begin
      seg_d        = pat_s ^ SEG_OFF;
      an_d         = an_on_s ^ AN_OFF;
      nxt_d        = (nxt_q == NXT_LAST) ? {NW{1'b0}} : nxt_q + NW'(1);
      frame_done_d = (nxt_q == NXT_LAST);
    end else begin
      seg_d        = seg_q;
      an_d         = an_q;
      nxt_d        = nxt_q;
      frame_done_d = 1'b0;
    end
  end

  // State registers; reset drives the pins to their inactive level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q        <= {(4*NUMBCDS){1'b0}};
      ovf_q        <= 1'b0;
      presc_q      <= {PW{1'b0}};
      nxt_q        <= {NW{1'b0}};
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      bcd_q        <= bcd_d;
      ovf_q        <= ovf_d;
      presc_q      <= presc_d;
      nxt_q        <= nxt_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: a cycle-level display model pushes expected slots, a monitor pops and compares.
// An active-high and an active-low instance run side by side on the same stimulus.
module tb_bcd_display_scan;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam logic [6:0] SEG_TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic          clk, reset, load, ovf;
  logic [15:0]   bcd;
  logic [6:0]    seg_s, seg_al;
  logic [N-1:0]  an_s, an_al;
  logic          fd_s, fd_al;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         fd;
    int           at;
  } exp_t;
  exp_t exp_q[$];

  int          edge_no = 0;
  int          cyc = 0;
  int          tick_cnt = 0;
  logic [15:0] m_bcd = 16'h0;
  logic        m_ovf = 1'b0;

  bcd_display_scan #(.NUMBCDS(N), .CLK_DIV(CD), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .reset(reset), .load(load), .bcd(bcd), .ovf(ovf),
    .seg(seg_s), .an(an_s), .frame_done(fd_s));

  bcd_display_scan #(.NUMBCDS(N), .CLK_DIV(CD), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .reset(reset), .load(load), .bcd(bcd), .ovf(ovf),
    .seg(seg_al), .an(an_al), .frame_done(fd_al));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int slot, input logic [15:0] b, input logic o);
    logic [15:0] hi;
    int dig;
    hi  = b >> (4 * slot);
    dig = int'(hi & 16'h000F);
    if (o) return 7'h40;
`ifdef BCD_SCAN_LZB_EN
    if (slot >= 1 && hi == 16'h0000) return 7'h00;
`endif
    if (dig > 9) return 7'h40;
    return SEG_TAB[dig];
  endfunction

  // Reference model: every CD-th edge after release shows the next digit of the held value.
  initial begin
    exp_t e;
    int slot;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        cyc = 0; tick_cnt = 0; m_bcd = 16'h0; m_ovf = 1'b0;
        exp_q.delete();
      end else begin
        edge_no++;
        cyc++;
        if (cyc % CD == 0) begin
          slot  = tick_cnt % N;
          e.an  = N'(1 << slot);
          e.seg = exp_seg(slot, m_bcd, m_ovf);
          e.fd  = (slot == N - 1);
          e.at  = edge_no;
          exp_q.push_back(e);
          tick_cnt++;
        end
        if (load) begin
          m_bcd = bcd;
          m_ovf = ovf;
        end
      end
    end
  end

  // Monitor: pop on a due slot, otherwise outputs must hold with frame_done low.
  initial begin
    exp_t e;
    logic [N-1:0] cur_an;
    logic [6:0]   cur_seg;
    logic [N-1:0] inv_an;
    logic [6:0]   inv_seg;
    cur_an = '0; cur_seg = 7'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_seg", seg_s, 7'h00);
        chk("rst_an", an_s, 4'h0);
        chk("rst_fd", fd_s, 1'b0);
        chk("rst_seg_al", seg_al, 7'h7F);
        chk("rst_an_al", an_al, 4'hF);
        cur_an = '0; cur_seg = 7'h00;
      end else if (exp_q.size() > 0 && exp_q[0].at <= edge_no) begin
        e = exp_q.pop_front();
        chk("slot_time", edge_no, e.at);
        chk("slot_an", an_s, e.an);
        chk("slot_seg", seg_s, e.seg);
        chk("slot_fd", fd_s, e.fd);
        inv_an = ~e.an; inv_seg = ~e.seg;
        chk("slot_an_al", an_al, inv_an);
        chk("slot_seg_al", seg_al, inv_seg);
        chk("slot_fd_al", fd_al, e.fd);
        cur_an = e.an; cur_seg = e.seg;
      end else begin
        chk("idle_fd", fd_s, 1'b0);
        chk("hold_an", an_s, cur_an);
        chk("hold_seg", seg_s, cur_seg);
        inv_an = ~cur_an;
        chk("hold_an_al", an_al, inv_an);
      end
    end
  end

  task automatic do_load(input logic [15:0] b, input logic o);
    @(negedge clk);
    load = 1'b1; bcd = b; ovf = o;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int gap;
    int len;
    logic [15:0] r;
    reset = 1'b1; load = 1'b0; bcd = 16'h0; ovf = 1'b0;
    run(3);
    reset = 1'b0;
    run(2 * N * CD);

    do_load(16'h0255, 1'b0);
    run(2 * N * CD);

    do_load(16'h9999, 1'b0);
    run(N * CD + 2);
    for (int k = 0; k < 2 * CD; k++) begin
      if ((cyc + 1) % CD == 0) break;
      @(negedge clk);
    end
    load = 1'b1; bcd = 16'h0000; ovf = 1'b0;
    @(negedge clk);
    load = 1'b0;
    run(2 * N * CD);

    do_load(16'h6383, 1'b1);
    run(2 * N * CD);
    do_load(16'h0A00, 1'b0);
    run(2 * N * CD);
    do_load(16'h0001, 1'b0);
    run(N * CD + 3);

    // Asynchronous reset in the middle of a slot.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_seg", seg_s, 7'h00);
    chk("async_an", an_s, 4'h0);
    chk("async_fd", fd_s, 1'b0);
    chk("async_seg_al", seg_al, 7'h7F);
    chk("async_an_al", an_al, 4'hF);
    run(2);
    reset = 1'b0;
    run(2 * N * CD);

    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 2) == 0) r = r & 16'h00FF;
        load = 1'b1; bcd = r; ovf = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      load = 1'b0;
      gap = $urandom_range(0, 12);
      run(gap);
    end

    run(2 * N * CD);
    @(negedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
